expander_rx_fifo: RTL and testbench
===================================

Name: expander_rx_fifo

Overview:
- Slave peripheral that sits directly downstream of the bus expander. It occupies two expander register slots: a DATA slot and a STATUS/CONTROL slot.
- A local producer, such as a UART receiver or sampler, pushes 16-bit words into an internal FIFO. The MCU drains the FIFO through the expander's two-cycle read sequence.
- Pops are triggered only by the expander's single read-ack pulse, so the expander's throwaway read never loses data.
- Provides sticky overflow/underflow flags, flush, and a level-threshold interrupt.

Parameters:
- DEPTH, 16, FIFO depth in words; power of 2, 2..128.
- AW, 4, pointer width, equal to log2(DEPTH).
- THRESH_RESET, 1, reset value of the irq threshold register.

Ports:
- sysclk  in  1  system clock, all flops on rising edge.
- sysreset  in  1  reset, asynchronous, active-high.
- push  in  1  producer strobe; one word per cycle asserted.
- push_data  in  16  word pushed when push=1.
- data_r  out  16  to expander r[DATA]; combinational FIFO head word, 16'h0000 when empty.
- data_read  in  1  from expander r_read[DATA]; pop strobe.
- status_r  out  16  to expander r[STATUS].
- status_load  in  1  from expander r_load[STATUS]; control write strobe.
- load_data  in  16  from expander r_load_data.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset (async, sysreset=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - ovf=0, udf=0, thresh=THRESH_RESET, irq=0.
  - data_r=0, status_r=16'h2000 (empty flag only).
  - Reset asserted mid-operation discards all contents immediately.
- Storage: DEPTH x 16 array written on accepted push. Pointers are AW bits and wrap naturally from DEPTH-1 to 0. count is AW+1 bits, range 0..DEPTH.
- Head presentation:
  - data_r = mem[rd_ptr] whenever count!=0; it must be combinational from registered state.
  - The expander samples r on both of its read cycles. The value captured on the data_read cycle is the pre-pop head.
  - The new head is visible the cycle after the pop.
- Pop: on data_read=1 with count!=0, rd_ptr+1 and count-1. On data_read=1 with count==0, no pointer change and udf<=1.
- Push:
  - Accepted when push=1 and (count<DEPTH or pop accepted same cycle): write mem[wr_ptr], wr_ptr+1, count+1.
  - Dropped when push=1 and count==DEPTH with no accepted pop: ovf<=1, contents untouched.
- Simultaneous push+pop:
  - With count in 1..DEPTH, both succeed and count is unchanged.
  - With count==0, the push is accepted, the pop is ignored, and udf<=1.
- status_r = {ovf, full, empty, udf, 4'b0, count zero-extended to 8 bits}.
  - full = (count==DEPTH), empty = (count==0).
  - Combinational from registers; reading it has no side effects.
- Control write (status_load=1), fields in load_data:
  - [15]=1 clears ovf.
  - [14]=1 flushes: pointers and count go to 0.
  - [12]=1 clears udf.
  - [7:0] always load thresh.
  - All fields take effect on the same edge.
- Priorities within one cycle:
  - Flush beats push/pop; a push during a flush is dropped without setting ovf.
  - Sticky set beats clear: a new overflow or underflow in the same cycle as a clear leaves the flag at 1.
- irq:
  - Registered: irq <= (thresh!=0) && (count_next >= thresh).
  - Asserts on the edge that makes count reach thresh. Zero latency beyond that edge; deasserts likewise.
  - thresh=0 disables irq.
- No combinational path from data_read/push/status_load to any output, except through registered state.

Test Plan:
- Reset, then push 3 words 16'hA001, 16'hA002, 16'hA003 → status_r=16'h0003, data_r=16'hA001. Expander-style read: two sampled cycles, data_read only on the second → captured 16'hA001, then data_r=16'hA002 and count=2.
- Push 17 words 0..16 into DEPTH=16 → full=1, ovf=1, count=16, word 16 lost. Drain all 16 → values 0..15 in order, then empty=1. Write status 16'h8000 → ovf=0.
- At count=16, push 16'hBEEF with data_read in the same cycle → count stays 16, ovf stays 0, 16'hBEEF is last out after a full drain. Run 40 push/pop cycles to exercise pointer wrap.
- From empty, data_read=1 → udf=1, count=0, data_r=0. Same-cycle push 16'h1234 + data_read at empty → count=1, head 16'h1234. Write 16'h1000 → udf cleared.
- Write thresh=4 (16'h0004), push 3 words → irq=0; 4th push → irq=1 on that edge. One pop → irq=0. Write 16'h0000 → irq stays 0 at any count.
- With 5 words stored, write 16'h4000 while push=1 → count=0, empty=1, ovf=0. Assert sysreset asynchronously mid-burst → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/expander_rx_fifo.sv
// expander_rx_fifo: receive FIFO drained through two bus-expander slots (DATA, STATUS/CONTROL).
// Sticky overflow/underflow, flush, and a registered level-threshold interrupt.
`default_nettype none

module expander_rx_fifo #(
  parameter int         DEPTH        = 16,
  parameter int         AW           = 4,
  parameter logic [7:0] THRESH_RESET = 8'd1
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        push,
  input  logic [15:0] push_data,
  output logic [15:0] data_r,
  input  logic        data_read,
  output logic [15:0] status_r,
  input  logic        status_load,
  input  logic [15:0] load_data,
  output logic        irq
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    thresh_q, thresh_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          irq_q, irq_d;

  logic          empty, full, flush, pop_ok, push_ok;
  logic          unused_ctrl;

  assign unused_ctrl = ^{load_data[13], load_data[11:8]};

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    flush    = status_load & load_data[14];
    pop_ok   = data_read & ~empty & ~flush;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    push_ok  = push & ~flush & (~full | pop_ok);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    // Clears are applied first so a same-cycle event leaves the flag set.
    ovf_d = ovf_q;
    if (status_load && load_data[15]) ovf_d = 1'b0;
    if (push && !flush && full && !pop_ok) ovf_d = 1'b1;

    udf_d = udf_q;
    if (status_load && load_data[12]) udf_d = 1'b0;
    if (data_read && !flush && empty) udf_d = 1'b1;

    thresh_d = status_load ? load_data[7:0] : thresh_q;
    irq_d    = (thresh_d != 8'd0) && (8'(count_d) >= thresh_d);
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thresh_q <= THRESH_RESET;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is not reset; stale words are hidden because data_r is gated by count.
  always_ff @(posedge sysclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign data_r   = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign status_r = {ovf_q, full, empty, udf_q, 4'b0000, 8'(count_q)};
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_expander_rx_fifo.sv
// Directed self-checking bench for expander_rx_fifo (DEPTH=16).
`default_nettype none

module tb_expander_rx_fifo;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic        push;
  logic [15:0] push_data;
  logic [15:0] data_r;
  logic        data_read;
  logic [15:0] status_r;
  logic        status_load;
  logic [15:0] load_data;
  logic        irq;

  int n_chk  = 0;
  int n_pass = 0;

  expander_rx_fifo #(.DEPTH(16), .AW(4), .THRESH_RESET(8'd1)) dut (
    .sysclk      (sysclk),
    .sysreset    (sysreset),
    .push        (push),
    .push_data   (push_data),
    .data_r      (data_r),
    .data_read   (data_read),
    .status_r    (status_r),
    .status_load (status_load),
    .load_data   (load_data),
    .irq         (irq)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] v);
    push = 1'b1;
    push_data = v;
    tick();
    push = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    data_read = 1'b1;
    check(tag, data_r, exp);
    tick();
    data_read = 1'b0;
  endtask

  task automatic write_ctrl(input logic [15:0] v);
    status_load = 1'b1;
    load_data = v;
    tick();
    status_load = 1'b0;
  endtask

  initial begin
    sysreset = 1'b1;
    push = 1'b0; push_data = '0; data_read = 1'b0;
    status_load = 1'b0; load_data = '0;
    tick(); tick();
    check("rst_status", status_r, 16'h2000);
    check("rst_data", data_r, 16'h0000);
    check("rst_irq", 16'(irq), 16'h0000);
    sysreset = 1'b0;
    tick();

    // Basic push and expander-style two-cycle read
    push_word(16'hA001); push_word(16'hA002); push_word(16'hA003);
    check("p3_status", status_r, 16'h0003);
    check("p3_head", data_r, 16'hA001);
    check("p3_irq", 16'(irq), 16'h0001);
    check("rd_cycle1", data_r, 16'hA001);
    tick();
    pop_check("rd_cycle2", 16'hA001);
    check("rd_newhead", data_r, 16'hA002);
    check("rd_status", status_r, 16'h0002);

    // Overflow at full, then ordered drain
    write_ctrl(16'h4001);
    check("flush_status", status_r, 16'h2000);
    for (int i = 0; i < 17; i++) push_word(16'(i));
    check("ovf_status", status_r, 16'hC010);
    check("ovf_head", data_r, 16'h0000);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 16'(i));
    check("drain_status", status_r, 16'hA000);
    write_ctrl(16'h8000);
    check("ovf_clr", status_r, 16'h2000);

    // Push+pop at full, then pointer wrap
    for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i));
    push = 1'b1; push_data = 16'hBEEF; data_read = 1'b1;
    check("full_pp_head", data_r, 16'h0100);
    tick();
    push = 1'b0; data_read = 1'b0;
    check("full_pp_status", status_r, 16'h4010);
    for (int i = 1; i < 16; i++) pop_check($sformatf("pp_drain%0d", i), 16'h0100 + 16'(i));
    pop_check("pp_beef", 16'hBEEF);
    check("pp_empty", status_r, 16'h2000);
    push_word(16'h0200);
    for (int i = 1; i <= 40; i++) begin
      push = 1'b1; push_data = 16'h0200 + 16'(i); data_read = 1'b1;
      check($sformatf("wrap%0d", i), data_r, 16'h0200 + 16'(i - 1));
      tick();
    end
    push = 1'b0; data_read = 1'b0;
    check("wrap_status", status_r, 16'h0001);
    pop_check("wrap_last", 16'h0228);
    check("wrap_empty", status_r, 16'h2000);

    // Underflow and push+pop at empty
    data_read = 1'b1; tick(); data_read = 1'b0;
    check("udf_status", status_r, 16'h3000);
    check("udf_data", data_r, 16'h0000);
    push = 1'b1; push_data = 16'h1234; data_read = 1'b1;
    tick();
    push = 1'b0; data_read = 1'b0;
    check("emp_pp_status", status_r, 16'h1001);
    check("emp_pp_head", data_r, 16'h1234);
    write_ctrl(16'h1000);
    check("udf_clr", status_r, 16'h0001);
    pop_check("udf_pop", 16'h1234);

    // Threshold interrupt
    write_ctrl(16'h0004);
    push_word(16'h0011); check("th_irq1", 16'(irq), 16'h0000);
    push_word(16'h0022); check("th_irq2", 16'(irq), 16'h0000);
    push_word(16'h0033); check("th_irq3", 16'(irq), 16'h0000);
    push_word(16'h0044); check("th_irq4", 16'(irq), 16'h0001);
    check("th_status", status_r, 16'h0004);
    pop_check("th_pop", 16'h0011);
    check("th_irq_pop", 16'(irq), 16'h0000);
    write_ctrl(16'h0000);
    check("th_dis", 16'(irq), 16'h0000);
    push_word(16'h0055); push_word(16'h0066);
    check("th_dis5", 16'(irq), 16'h0000);
    check("th_status5", status_r, 16'h0005);

    // Flush with concurrent push
    push = 1'b1; push_data = 16'h0077; status_load = 1'b1; load_data = 16'h4000;
    tick();
    push = 1'b0; status_load = 1'b0;
    check("flpush_status", status_r, 16'h2000);
    check("flpush_data", data_r, 16'h0000);
    push_word(16'h0088);
    check("post_flush_head", data_r, 16'h0088);
    check("post_flush_status", status_r, 16'h0001);

    // Asynchronous reset mid-burst
    write_ctrl(16'h0001);
    check("pre_rst_irq", 16'(irq), 16'h0001);
    push_word(16'h0099);
    check("pre_rst_status", status_r, 16'h0002);
    push = 1'b1; push_data = 16'h00AA;
    #3;
    sysreset = 1'b1;
    #1;
    check("arst_status", status_r, 16'h2000);
    check("arst_data", data_r, 16'h0000);
    check("arst_irq", 16'(irq), 16'h0000);
    push = 1'b0;
    tick();
    sysreset = 1'b0;
    tick();
    push_word(16'h00AB);
    check("post_rst_irq", 16'(irq), 16'h0001);
    check("post_rst_head", data_r, 16'h00AB);
    check("post_rst_status", status_r, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
